// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use hazard unit for the rv32i EX stage.
// Holds a single-cycle load response in a buffer while the consumer is frozen.
module fwd_hazard_unit #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 2,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(NUM_STAGES + 2)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] prod_rd,
    input  logic [NUM_STAGES-1:0]            prod_wen,
    input  logic [NUM_STAGES-1:0]            prod_is_load,
    input  logic [NUM_STAGES*XLEN-1:0]       prod_data,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]    src_addr,
    input  logic [NUM_SRC-1:0]               src_used,
    input  logic                             data_mem_resp,
    input  logic [XLEN-1:0]                  data_mem_rdata,
    input  logic                             pipe_advance,
    input  logic                             flush,
    output logic [NUM_SRC*SEL_W-1:0]         fwd_sel,
    output logic [NUM_SRC*XLEN-1:0]          fwd_data,
    output logic                             stall_req,
    output logic                             load_buf_valid,
    output logic [CNT_W-1:0]                 stall_cycles
);

    localparam logic [SEL_W-1:0] SEL_LD = SEL_W'(NUM_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t          state;
    logic [XLEN-1:0] load_buf;

    logic [SEL_W-1:0] hit_sel  [NUM_SRC];
    logic [XLEN-1:0]  hit_data [NUM_SRC];
    logic [NUM_SRC-1:0] lu_op;
    logic             lu;

    // Only stage 0 can still be waiting on memory; older loads are final.
    logic unused_is_load;
    assign unused_is_load = ^prod_is_load;

    always_comb begin
        lu    = 1'b0;
        lu_op = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hit_sel[i]  = '0;
            hit_data[i] = '0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (src_used[i] && prod_wen[s] &&
                    prod_rd[s*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                    prod_rd[s*REG_ADDR_W +: REG_ADDR_W] ==
                    src_addr[i*REG_ADDR_W +: REG_ADDR_W]) begin
                    hit_sel[i]  = SEL_W'(s + 1);
                    hit_data[i] = prod_data[s*XLEN +: XLEN];
                end
            end
            lu_op[i] = prod_is_load[0] && hit_sel[i] == SEL_W'(1);
            lu       = lu | lu_op[i];
        end
    end

    always_comb begin
        fwd_sel  = '0;
        fwd_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (lu_op[i]) begin
                if (state == HOLD) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_LD;
                    fwd_data[i*XLEN +: XLEN]  = load_buf;
                end else if (data_mem_resp) begin
                    fwd_sel[i*SEL_W +: SEL_W] = SEL_LD;
                    fwd_data[i*XLEN +: XLEN]  = data_mem_rdata;
                end
            end else begin
                fwd_sel[i*SEL_W +: SEL_W] = hit_sel[i];
                fwd_data[i*XLEN +: XLEN]  = hit_data[i];
            end
        end
    end

    always_comb begin
        stall_req = 1'b0;
        unique case (state)
            IDLE:    stall_req = lu && !data_mem_resp;
            WAIT:    stall_req = !data_mem_resp;
            default: stall_req = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            load_buf       <= '0;
            load_buf_valid <= 1'b0;
            stall_cycles   <= '0;
        end else begin
            if (stall_req && stall_cycles != '1)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush) begin
                state          <= IDLE;
                load_buf_valid <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (lu && !data_mem_resp) begin
                            state <= WAIT;
                        end else if (lu && !pipe_advance) begin
                            state          <= HOLD;
                            load_buf       <= data_mem_rdata;
                            load_buf_valid <= 1'b1;
                        end
                    end
                    WAIT: begin
                        if (data_mem_resp) begin
                            if (pipe_advance) begin
                                state <= IDLE;
                            end else begin
                                state          <= HOLD;
                                load_buf       <= data_mem_rdata;
                                load_buf_valid <= 1'b1;
                            end
                        end
                    end
                    HOLD: begin
                        if (pipe_advance) begin
                            state          <= IDLE;
                            load_buf_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state          <= IDLE;
                        load_buf_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit; a second instance with CNT_W=2
// exercises stall counter saturation.
module tb_fwd_hazard_unit;

    logic        clk;
    logic        rst;
    logic [9:0]  prod_rd;
    logic [1:0]  prod_wen;
    logic [1:0]  prod_is_load;
    logic [63:0] prod_data;
    logic [9:0]  src_addr;
    logic [1:0]  src_used;
    logic        data_mem_resp;
    logic [31:0] data_mem_rdata;
    logic        pipe_advance;
    logic        flush;

    logic [3:0]  fwd_sel;
    logic [63:0] fwd_data;
    logic        stall_req;
    logic        load_buf_valid;
    logic [15:0] stall_cycles;

    logic [3:0]  fwd_sel2;
    logic [63:0] fwd_data2;
    logic        stall_req2;
    logic        load_buf_valid2;
    logic [1:0]  stall_cycles2;

    int pass_cnt;
    int total_cnt;

    fwd_hazard_unit dut (
        .clk(clk), .rst(rst),
        .prod_rd(prod_rd), .prod_wen(prod_wen),
        .prod_is_load(prod_is_load), .prod_data(prod_data),
        .src_addr(src_addr), .src_used(src_used),
        .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
        .pipe_advance(pipe_advance), .flush(flush),
        .fwd_sel(fwd_sel), .fwd_data(fwd_data),
        .stall_req(stall_req), .load_buf_valid(load_buf_valid),
        .stall_cycles(stall_cycles)
    );

    fwd_hazard_unit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .prod_rd(prod_rd), .prod_wen(prod_wen),
        .prod_is_load(prod_is_load), .prod_data(prod_data),
        .src_addr(src_addr), .src_used(src_used),
        .data_mem_resp(data_mem_resp), .data_mem_rdata(data_mem_rdata),
        .pipe_advance(pipe_advance), .flush(flush),
        .fwd_sel(fwd_sel2), .fwd_data(fwd_data2),
        .stall_req(stall_req2), .load_buf_valid(load_buf_valid2),
        .stall_cycles(stall_cycles2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        prod_rd        = '0;
        prod_wen       = '0;
        prod_is_load   = '0;
        prod_data      = '0;
        src_addr       = '0;
        src_used       = '0;
        data_mem_resp  = 1'b0;
        data_mem_rdata = '0;
        pipe_advance   = 1'b0;
        flush          = 1'b0;
    endtask

    // Load x8 in EX/MEM, consumed by rs2.
    task automatic set_load_use();
        clr_in();
        prod_rd      = {5'd0, 5'd8};
        prod_wen     = 2'b01;
        prod_is_load = 2'b01;
        prod_data    = {32'h0, 32'hBAD0BAD0};
        src_addr     = {5'd8, 5'd0};
        src_used     = 2'b10;
    endtask

    task automatic test_reset();
        clr_in();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #2;
        total_cnt++;
        if (stall_req !== 1'b0) $display("FAIL rst_stall got %0b exp 0", stall_req);
        else pass_cnt++;
        total_cnt++;
        if (load_buf_valid !== 1'b0) $display("FAIL rst_valid got %0b exp 0", load_buf_valid);
        else pass_cnt++;
        total_cnt++;
        if (stall_cycles !== 16'd0) $display("FAIL rst_cnt got %0d exp 0", stall_cycles);
        else pass_cnt++;
        total_cnt++;
        if (fwd_sel !== 4'd0 || fwd_data !== 64'd0)
            $display("FAIL rst_fwd got %h/%h exp 0/0", fwd_sel, fwd_data);
        else pass_cnt++;
    endtask

    task automatic test_alu_fwd();
        tick();
        clr_in();
        prod_rd      = {5'd6, 5'd5};
        prod_wen     = 2'b11;
        prod_is_load = 2'b10;
        prod_data    = {32'h20, 32'h10};
        src_addr     = {5'd6, 5'd5};
        src_used     = 2'b11;
        #2;
        total_cnt++;
        if (fwd_sel !== 4'b1001) $display("FAIL alu_sel got %b exp 1001", fwd_sel);
        else pass_cnt++;
        total_cnt++;
        if (fwd_data !== {32'h20, 32'h10})
            $display("FAIL alu_data got %h exp 0000002000000010", fwd_data);
        else pass_cnt++;
        total_cnt++;
        if (stall_req !== 1'b0) $display("FAIL alu_stall got %0b exp 0", stall_req);
        else pass_cnt++;
        src_used = 2'b01;
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0001 || fwd_data[63:32] !== 32'h0)
            $display("FAIL unused_op got %b/%h exp 0001/0", fwd_sel, fwd_data[63:32]);
        else pass_cnt++;
    endtask

    task automatic test_priority();
        tick();
        clr_in();
        prod_rd   = {5'd7, 5'd7};
        prod_wen  = 2'b11;
        prod_data = {32'hB, 32'hA};
        src_addr  = {5'd0, 5'd7};
        src_used  = 2'b01;
        #2;
        total_cnt++;
        if (fwd_sel[1:0] !== 2'd1 || fwd_data[31:0] !== 32'hA)
            $display("FAIL prio_young got %0d/%h exp 1/a", fwd_sel[1:0], fwd_data[31:0]);
        else pass_cnt++;
        prod_rd  = 10'd0;
        src_addr = 10'd0;
        #1;
        total_cnt++;
        if (fwd_sel[1:0] !== 2'd0 || fwd_data[31:0] !== 32'h0)
            $display("FAIL prio_x0 got %0d/%h exp 0/0", fwd_sel[1:0], fwd_data[31:0]);
        else pass_cnt++;
        prod_rd  = {5'd3, 5'd9};
        src_addr = {5'd9, 5'd9};
        src_used = 2'b11;
        #1;
        total_cnt++;
        if (fwd_sel !== 4'b0101 || fwd_data !== {32'hA, 32'hA})
            $display("FAIL prio_both got %b/%h exp 0101/a,a", fwd_sel, fwd_data);
        else pass_cnt++;
    endtask

    task automatic test_load_wait();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_load_use();
        for (int c = 0; c < 3; c++) begin
            #2;
            total_cnt++;
            if (stall_req !== 1'b1 || fwd_sel[3:2] !== 2'd0)
                $display("FAIL lw_stall%0d got %0b/%0d exp 1/0", c, stall_req, fwd_sel[3:2]);
            else pass_cnt++;
            tick();
        end
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'hDEAD;
        pipe_advance   = 1'b1;
        #2;
        total_cnt++;
        if (stall_req !== 1'b0 || fwd_sel[3:2] !== 2'd3 || fwd_data[63:32] !== 32'hDEAD)
            $display("FAIL lw_resp got %0b/%0d/%h exp 0/3/dead",
                     stall_req, fwd_sel[3:2], fwd_data[63:32]);
        else pass_cnt++;
        total_cnt++;
        if (stall_cycles !== 16'd3) $display("FAIL lw_cnt got %0d exp 3", stall_cycles);
        else pass_cnt++;
        tick();
        data_mem_resp  = 1'b0;
        data_mem_rdata = 32'h0;
        pipe_advance   = 1'b0;
        #2;
        total_cnt++;
        if (stall_req !== 1'b1 || load_buf_valid !== 1'b0)
            $display("FAIL lw_idle got %0b/%0b exp 1/0", stall_req, load_buf_valid);
        else pass_cnt++;
        tick();
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'hBEEF;
        #2;
        total_cnt++;
        if (stall_req !== 1'b0 || fwd_data[63:32] !== 32'hBEEF)
            $display("FAIL hold_resp got %0b/%h exp 0/beef", stall_req, fwd_data[63:32]);
        else pass_cnt++;
        tick();
        data_mem_resp  = 1'b0;
        data_mem_rdata = 32'h1234;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b1 || stall_req !== 1'b0 ||
            fwd_sel[3:2] !== 2'd3 || fwd_data[63:32] !== 32'hBEEF)
            $display("FAIL hold1 got %0b/%0b/%0d/%h exp 1/0/3/beef",
                     load_buf_valid, stall_req, fwd_sel[3:2], fwd_data[63:32]);
        else pass_cnt++;
        total_cnt++;
        if (stall_cycles !== 16'd4) $display("FAIL hold_cnt got %0d exp 4", stall_cycles);
        else pass_cnt++;
        tick();
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'h5678;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b1 || fwd_data[63:32] !== 32'hBEEF)
            $display("FAIL hold2 got %0b/%h exp 1/beef", load_buf_valid, fwd_data[63:32]);
        else pass_cnt++;
        tick();
        data_mem_resp = 1'b0;
        pipe_advance  = 1'b1;
        #2;
        total_cnt++;
        if (fwd_data[63:32] !== 32'hBEEF)
            $display("FAIL hold_adv got %h exp beef", fwd_data[63:32]);
        else pass_cnt++;
        tick();
        pipe_advance = 1'b0;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b0 || stall_req !== 1'b1)
            $display("FAIL hold_exit got %0b/%0b exp 0/1", load_buf_valid, stall_req);
        else pass_cnt++;
    endtask

    task automatic test_flush();
        tick();
        flush = 1'b1;
        #2;
        total_cnt++;
        if (stall_req !== 1'b1) $display("FAIL fl_wait got %0b exp 1", stall_req);
        else pass_cnt++;
        tick();
        flush    = 1'b0;
        prod_wen = 2'b00;
        #2;
        total_cnt++;
        if (stall_req !== 1'b0 || load_buf_valid !== 1'b0)
            $display("FAIL fl_idle got %0b/%0b exp 0/0", stall_req, load_buf_valid);
        else pass_cnt++;
        tick();
        prod_wen       = 2'b01;
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'h77;
        #2;
        tick();
        flush         = 1'b1;
        data_mem_resp = 1'b0;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b1 || fwd_data[63:32] !== 32'h77)
            $display("FAIL fl_hold got %0b/%h exp 1/77", load_buf_valid, fwd_data[63:32]);
        else pass_cnt++;
        tick();
        flush = 1'b0;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b0 || stall_req !== 1'b1)
            $display("FAIL fl_hold_exit got %0b/%0b exp 0/1", load_buf_valid, stall_req);
        else pass_cnt++;
        tick();
        flush          = 1'b1;
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'h99;
        #2;
        total_cnt++;
        if (stall_req !== 1'b0 || fwd_data[63:32] !== 32'h99)
            $display("FAIL fl_resp got %0b/%h exp 0/99", stall_req, fwd_data[63:32]);
        else pass_cnt++;
        tick();
        flush         = 1'b0;
        data_mem_resp = 1'b0;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b0 || stall_req !== 1'b1)
            $display("FAIL fl_nocap got %0b/%0b exp 0/1", load_buf_valid, stall_req);
        else pass_cnt++;
        tick();
        data_mem_resp = 1'b1;
        pipe_advance  = 1'b1;
    endtask

    task automatic test_reset_hold();
        tick();
        set_load_use();
        data_mem_resp  = 1'b1;
        data_mem_rdata = 32'hAB;
        tick();
        rst           = 1'b1;
        data_mem_resp = 1'b0;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b1 || fwd_data[63:32] !== 32'hAB)
            $display("FAIL rh_pre got %0b/%h exp 1/ab", load_buf_valid, fwd_data[63:32]);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        #2;
        total_cnt++;
        if (load_buf_valid !== 1'b0 || stall_req !== 1'b1 || stall_cycles !== 16'd0)
            $display("FAIL rh_post got %0b/%0b/%0d exp 0/1/0",
                     load_buf_valid, stall_req, stall_cycles);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_load_use();
        repeat (2) tick();
        #2;
        total_cnt++;
        if (stall_cycles2 !== 2'd2) $display("FAIL sat_mid got %0d exp 2", stall_cycles2);
        else pass_cnt++;
        repeat (4) tick();
        #2;
        total_cnt++;
        if (stall_cycles2 !== 2'd3) $display("FAIL sat_cnt got %0d exp 3", stall_cycles2);
        else pass_cnt++;
        total_cnt++;
        if (stall_cycles !== 16'd6) $display("FAIL sat_wide got %0d exp 6", stall_cycles);
        else pass_cnt++;
        data_mem_resp = 1'b1;
        pipe_advance  = 1'b1;
        tick();
        clr_in();
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst       = 1'b0;
        clr_in();
        test_reset();
        test_alu_fwd();
        test_priority();
        test_load_wait();
        test_flush();
        test_reset_hold();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the rv32i pipeline; next generation of the EX-stage forwarding logic.
- Generalised to NUM_SRC consumer operands and NUM_STAGES producer stages, with a uniform priority scheme.
- Adds a sequential load-wait FSM and a load-data capture buffer, so a single-cycle data_mem_resp pulse is never lost while the consumer is frozen.
- Adds a saturating stall-cycle counter.
- Sits beside the ID/EX register, driving the operand muxes of the ALU and the branch comparator.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.
- NUM_SRC, 2, number of consumer operands (rs1, rs2, ...).
- NUM_STAGES, 2, producer stages after EX; index 0 = EX/MEM (youngest), 1 = MEM/WB, and so on.
- CNT_W, 16, stall counter width.
- Derived: SEL_W = $clog2(NUM_STAGES+2).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- prod_rd  in  NUM_STAGES*REG_ADDR_W  destination register per producer stage
- prod_wen  in  NUM_STAGES  producer writes the register file
- prod_is_load  in  NUM_STAGES  producer is a load
- prod_data  in  NUM_STAGES*XLEN  producer result (ALU out or regfilemux out)
- src_addr  in  NUM_SRC*REG_ADDR_W  consumer source registers in ID/EX
- src_used  in  NUM_SRC  operand actually read by the consumer
- data_mem_resp  in  1  one-cycle response pulse for the load in stage 0
- data_mem_rdata  in  XLEN  load data, valid only while data_mem_resp=1
- pipe_advance  in  1  ID/EX register advances this cycle
- flush  in  1  kill the consumer in ID/EX
- fwd_sel  out  NUM_SRC*SEL_W  per operand: 0 = regfile; k = 1..NUM_STAGES selects stage k-1; NUM_STAGES+1 selects load data
- fwd_data  out  NUM_SRC*XLEN  selected forwarded value (0 when sel=0)
- stall_req  out  1  freeze IF/ID/ID-EX
- load_buf_valid  out  1  capture buffer holds data
- stall_cycles  out  CNT_W  saturating count of cycles with stall_req=1

Behaviour:
- Match definition, operand i vs stage s: src_used[i] & prod_wen[s] & prod_rd[s]!=0 & prod_rd[s]==src_addr[i].
- Priority: the lowest matching s wins. Non-load match gives sel=s+1, data=prod_data[s].
- A load match at s>0 is treated as non-load; prod_data is already final there.
- Load match at s=0 (load-use), per operand:
  - In IDLE with data_mem_resp=1: sel=NUM_STAGES+1, data=data_mem_rdata.
  - In IDLE with data_mem_resp=0: sel=0, stall_req=1.
  - In HOLD: sel=NUM_STAGES+1, data=load_buf.
- FSM states are IDLE, WAIT, HOLD; lu = any operand has a load-use match.
- IDLE transitions:
  - lu & !resp -> WAIT.
  - lu & resp & !pipe_advance -> HOLD; capture rdata into load_buf.
  - Otherwise stay in IDLE.
- WAIT:
  - stall_req=1 while resp=0.
  - On resp: stall_req=0 and forward data_mem_rdata that cycle.
  - Then -> IDLE if pipe_advance, else -> HOLD with rdata captured.
- HOLD:
  - stall_req=0.
  - load_buf_valid=1; buffer data overrides all stages for the load-use operands.
  - -> IDLE on pipe_advance.
  - data_mem_resp is ignored in this state.
- stall_req is purely combinational from state and inputs, with zero latency. fwd_sel and fwd_data are combinational.
- flush (any state) -> IDLE next cycle and load_buf_valid cleared. The same-cycle outputs are still computed normally.
- stall_cycles increments on each cycle with stall_req=1, saturates at all-ones, and never wraps.
- Reset, including mid-WAIT or mid-HOLD:
  - state=IDLE, load_buf=0, load_buf_valid=0, stall_cycles=0.
  - Combinational outputs follow the inputs in IDLE.
- Simultaneous flush & resp: flush wins, the buffer is not captured.
- The same stage matching multiple operands yields the same sel for each.

Test Plan:
- EX/MEM ALU x5=0x10 (wen, no load); rs1=x5, rs2=x6; MEM/WB x6=0x20 -> fwd_sel={rs1:1, rs2:2}, fwd_data={0x10, 0x20}, stall_req=0.
- Both stages write x7 (0xA, 0xB); rs1=x7 -> sel=1, data=0xA (youngest). With rd=x0 in both -> sel=0, data=0.
- Load x8 in stage 0, rs2=x8, resp low for 3 cycles then high with rdata=0xDEAD and pipe_advance=1:
  - stall_req=1 for 3 cycles; on the resp cycle sel=3, data=0xDEAD, stall_req=0; then IDLE.
  - stall_cycles=3.
- Same load, resp with rdata=0xBEEF while pipe_advance=0 for 2 more cycles, rdata changes to garbage:
  - HOLD, load_buf_valid=1, data stays 0xBEEF; IDLE after the advance.
- In WAIT assert flush -> next cycle IDLE, load_buf_valid=0. Separately, assert rst in HOLD -> next cycle all state cleared, stall_cycles=0.
- With CNT_W=2, stall 6 cycles -> stall_cycles saturates at 3.
